// File: rtl/qea_host_loader.sv
// Host-side sequencer for the QEA: streams gate context into context RAM, seeds the
// state RAM with |0>, starts the accelerator, times the run and streams the final state back out.
module qea_host_loader #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [63:0]                          i_ctx_word,
    output logic                                 o_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [63:0]                          o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_cycles
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD_CTX   = 4'd1;
    localparam logic [3:0] S_INIT_STATE = 4'd2;
    localparam logic [3:0] S_START      = 4'd3;
    localparam logic [3:0] S_RUN        = 4'd4;
    localparam logic [3:0] S_RD_ADDR    = 4'd5;
    localparam logic [3:0] S_RD_WAIT    = 4'd6;
    localparam logic [3:0] S_RD_OUT     = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam int DW       = PE_NUM * STATE_DATA_WIDTH;
    localparam int QBIT_MAX = STATE_ADDR_WIDTH + 2;

    // Amplitude 1.0 in Q2.30 on the real half, placed in the top lane.
    localparam logic [STATE_DATA_WIDTH-1:0] AMP_ONE   = STATE_DATA_WIDTH'(1) << (STATE_DATA_WIDTH - 2);
    localparam logic [DW-1:0]               INIT_WORD = DW'(AMP_ONE) << (DW - STATE_DATA_WIDTH);

    logic [3:0]                          r_state;
    logic [MAX_QBIT_WIDTH-1:0]           r_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ins_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_cnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_addr;
    logic                                r_ctx_en;
    logic [63:0]                         r_ctx_data;
    logic [STATE_ADDR_WIDTH-1:0]         r_addr;
    logic [STATE_ADDR_WIDTH-1:0]         r_last;
    logic [31:0]                         r_cycles;
    logic                                r_err;
    logic [DW-1:0]                       r_rd_data;

    logic                                w_go_ok;
    logic [31:0]                         w_shift;
    logic [STATE_ADDR_WIDTH-1:0]         w_last_addr;
    logic                                w_last_ctx;
    logic                                w_init;
    logic                                w_rd;

    assign w_go_ok = (32'(i_qbit_num) >= 32'd3) && (32'(i_qbit_num) <= 32'(QBIT_MAX));

    // N-1 = 2^(q-2)-1 built by shifting ones down, so q = QBIT_MAX yields all ones without overflow.
    assign w_shift     = 32'(QBIT_MAX) - 32'(i_qbit_num);
    assign w_last_addr = {STATE_ADDR_WIDTH{1'b1}} >> w_shift;
    assign w_last_ctx  = (r_ctx_cnt == (r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1)));

    // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_qbit_num <= '0;
            r_ins_num  <= '0;
            r_ctx_cnt  <= '0;
            r_ctx_addr <= '0;
            r_ctx_en   <= 1'b0;
            r_ctx_data <= '0;
            r_addr     <= '0;
            r_last     <= '0;
            r_cycles   <= '0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ctx_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        if (w_go_ok) begin
                            r_err      <= 1'b0;
                            r_qbit_num <= i_qbit_num;
                            r_ins_num  <= i_ins_num;
                            r_last     <= w_last_addr;
                            r_ctx_cnt  <= '0;
                            r_addr     <= '0;
                            r_state    <= (i_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_CTX: begin
                    if (i_ctx_valid) begin
                        r_ctx_en   <= 1'b1;
                        r_ctx_data <= i_ctx_word;
                        r_ctx_addr <= r_ctx_cnt;
                        r_ctx_cnt  <= r_ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
                        if (w_last_ctx) begin
                            r_state <= S_INIT_STATE;
                        end
                    end
                end
                S_INIT_STATE: begin
                    if (r_addr == r_last) begin
                        r_addr  <= '0;
                        r_state <= S_START;
                    end else begin
                        r_addr <= r_addr + STATE_ADDR_WIDTH'(1);
                    end
                end
                S_START: begin
                    r_cycles <= '0;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    if (r_cycles != '1) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                    if (i_complete) begin
                        r_state <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_rd_data <= i_state_dout;
                    r_state   <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (i_rd_ready) begin
                        if (r_addr == r_last) begin
                            r_addr  <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + STATE_ADDR_WIDTH'(1);
                            r_state <= S_RD_ADDR;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_init = (r_state == S_INIT_STATE);
    assign w_rd   = (r_state == S_RD_ADDR);

    assign o_ctx_ready   = (r_state == S_LOAD_CTX);
    assign o_start       = (r_state == S_START);
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_rd_valid    = (r_state == S_RD_OUT);
    assign o_qbit_num    = r_qbit_num;
    assign o_ctx_en      = r_ctx_en;
    assign o_ctx_wea     = r_ctx_en;
    assign o_ctx_addr    = r_ctx_addr;
    assign o_ctx_data    = r_ctx_data;
    assign o_state_ena   = (w_init || w_rd) ? {PE_NUM{1'b1}} : {PE_NUM{1'b0}};
    assign o_state_wea   = w_init ? {PE_NUM{1'b1}} : {PE_NUM{1'b0}};
    assign o_state_addra = r_addr;
    assign o_state_dina  = (w_init && (r_addr == '0)) ? INIT_WORD : '0;
    assign o_rd_data     = r_rd_data;
    assign o_err         = r_err;
    assign o_cycles      = r_cycles;

endmodule

// File: tb/tb_qea_host_loader.sv
// Scoreboard bench for qea_host_loader: expected context writes, state writes and readout
// words are queued as stimulus is issued and popped by a background monitor as the DUT emits them.
module tb_qea_host_loader;

    localparam int PE   = 4;
    localparam int SDW  = 64;
    localparam int SAW  = 8;
    localparam int GCAW = 16;
    localparam int MQW  = 6;
    localparam int DW   = PE * SDW;

    localparam logic [DW-1:0] AMP_TOP = {64'h40000000_00000000, 192'd0};

    typedef struct packed {
        logic [GCAW-1:0] addr;
        logic [63:0]     data;
    } ctx_t;

    typedef struct packed {
        logic [SAW-1:0] addr;
        logic [DW-1:0]  data;
    } st_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_go;
    logic [MQW-1:0]  i_qbit_num;
    logic [GCAW-1:0] i_ins_num;
    logic            i_ctx_valid;
    logic            o_ctx_ready;
    logic [63:0]     i_ctx_word;
    logic            o_start;
    logic [MQW-1:0]  o_qbit_num;
    logic            o_ctx_en;
    logic            o_ctx_wea;
    logic [GCAW-1:0] o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic [PE-1:0]   o_state_ena;
    logic [PE-1:0]   o_state_wea;
    logic [SAW-1:0]  o_state_addra;
    logic [DW-1:0]   o_state_dina;
    logic            i_complete;
    logic [DW-1:0]   ram_dout = '0;
    logic            o_rd_valid;
    logic            i_rd_ready;
    logic [DW-1:0]   o_rd_data;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic [31:0]     o_cycles;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] seed         = 16'd0;
    int          last_q       = 0;

    ctx_t        ctx_q[$];
    st_t         st_q[$];
    logic [DW-1:0] rd_q[$];

    wire [653:0] all_outs = {o_ctx_ready, o_start, o_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr,
                             o_ctx_data, o_state_ena, o_state_wea, o_state_addra, o_state_dina,
                             o_rd_valid, o_rd_data, o_busy, o_done, o_err, o_cycles};

    qea_host_loader #(
        .PE_NUM(PE), .STATE_DATA_WIDTH(SDW), .STATE_ADDR_WIDTH(SAW),
        .GATE_CONTEXT_ADDR_WIDTH(GCAW), .MAX_QBIT_WIDTH(MQW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_word(i_ctx_word),
        .o_start(o_start), .o_qbit_num(o_qbit_num), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
        .o_state_wea(o_state_wea), .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
        .i_complete(i_complete), .i_state_dout(ram_dout), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_cycles(o_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [SAW-1:0] a, input logic [15:0] s);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < PE; l++) v[l*64 +: 64] = {16'hA5C3, s, 8'(l), 16'h0000, a};
        return v;
    endfunction

    // State RAM read port with one cycle of latency; contents are a per-run address pattern.
    always @(posedge clk) begin
        if ((o_state_ena != '0) && (o_state_wea == '0)) ram_dout <= pat(o_state_addra, seed);
    end

    task automatic monitor();
        ctx_t          ce;
        st_t           se;
        logic [DW-1:0] re;
        logic          pv = 1'b0;
        logic          pr = 1'b0;
        logic [DW-1:0] pd = '0;
        forever begin
            @(negedge clk);
            if (o_ctx_en) begin
                tests_run++;
                if (ctx_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL ctx_write: got unexpected write addr=%0h, required none", o_ctx_addr);
                end else begin
                    ce = ctx_q.pop_front();
                    if ({o_ctx_wea, o_ctx_addr, o_ctx_data} !== {1'b1, ce.addr, ce.data}) begin
                        tests_failed++;
                        $display("FAIL ctx_write: got wea=%0b addr=%0h data=%h, required wea=1 addr=%0h data=%h",
                                 o_ctx_wea, o_ctx_addr, o_ctx_data, ce.addr, ce.data);
                    end
                end
            end
            if (o_state_wea != '0) begin
                tests_run++;
                if (st_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL state_write: got unexpected write addr=%0h, required none", o_state_addra);
                end else begin
                    se = st_q.pop_front();
                    if ({o_state_ena, o_state_wea, o_state_addra, o_state_dina} !==
                        {{PE{1'b1}}, {PE{1'b1}}, se.addr, se.data}) begin
                        tests_failed++;
                        $display("FAIL state_write: got ena=%h wea=%h addr=%0h top=%h, required ena=f wea=f addr=%0h top=%h",
                                 o_state_ena, o_state_wea, o_state_addra, o_state_dina[DW-1 -: 64],
                                 se.addr, se.data[DW-1 -: 64]);
                    end
                end
            end
            if (o_rd_valid && i_rd_ready) begin
                tests_run++;
                if (rd_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL readout: got unexpected word, required none");
                end else begin
                    re = rd_q.pop_front();
                    if (o_rd_data !== re) begin
                        tests_failed++;
                        $display("FAIL readout: got lane0=%h, required lane0=%h", o_rd_data[63:0], re[63:0]);
                    end
                end
            end
            if (o_rd_valid && pv && !pr) begin
                tests_run++;
                if (o_rd_data !== pd) begin
                    tests_failed++;
                    $display("FAIL rd_stable: got lane0=%h while stalled, required lane0=%h", o_rd_data[63:0], pd[63:0]);
                end
            end
            pv = o_rd_valid;
            pr = i_rd_ready;
            pd = o_rd_data;
        end
    endtask

    task automatic pulse_go(input int q, input int ins);
        @(posedge clk); #1;
        i_go       = 1'b1;
        i_qbit_num = MQW'(q);
        i_ins_num  = GCAW'(ins);
        @(posedge clk); #1;
        i_go       = 1'b0;
        i_qbit_num = '0;
        i_ins_num  = '0;
    endtask

    task automatic run_flow(input int q, input int ins, input int cdelay, input int stall,
                            input bit ctx_stall, input bit go_in_run);
        int          n;
        bit          found;
        logic [63:0] w[$];
        logic [63:0] word;
        n    = 1 << (q - 2);
        seed = seed + 16'd1;
        for (int i = 0; i < ins; i++) begin
            word = {$urandom, $urandom};
            w.push_back(word);
            ctx_q.push_back('{addr: GCAW'(i), data: word});
        end
        for (int a = 0; a < n; a++) begin
            st_q.push_back('{addr: SAW'(a), data: (a == 0) ? AMP_TOP : '0});
            rd_q.push_back(pat(SAW'(a), seed));
        end

        pulse_go(q, ins);
        @(negedge clk);
        tests_run++;
        if ({o_busy, o_err, o_qbit_num, o_ctx_ready} !== {1'b1, 1'b0, MQW'(q), (ins > 0)}) begin
            tests_failed++;
            $display("FAIL go_accept: got busy=%0b err=%0b qbit=%0d ctx_ready=%0b, required 1 0 %0d %0b",
                     o_busy, o_err, o_qbit_num, o_ctx_ready, q, (ins > 0));
        end
        last_q = q;

        if (ins > 0) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < ins; i++) begin
            if (ctx_stall && i == 1) begin
                i_ctx_valid = 1'b0;
                @(posedge clk); #1;
            end
            i_ctx_valid = 1'b1;
            i_ctx_word  = w[i];
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                found = o_ctx_ready;
                @(posedge clk); #1;
                if (found) break;
            end
            if (!found) begin
                tests_run++;
                tests_failed++;
                i_ctx_valid = 1'b0;
                $display("FAIL ctx_handshake: got no ready for word %0d, required ready", i);
                return;
            end
        end
        i_ctx_valid = 1'b0;
        i_ctx_word  = '0;

        found = 1'b0;
        for (int k = 0; k < n + ins + 100; k++) begin
            @(negedge clk);
            if (o_start) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL start_seen: got o_start=0 within budget, required 1");
            return;
        end
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_pulse: got o_start=%0b one cycle later, required 0", o_start);
        end

        for (int k = 1; k < cdelay; k++) begin
            @(posedge clk); #1;
            i_go       = (go_in_run && k == 1);
            i_qbit_num = (go_in_run && k == 1) ? MQW'(2) : MQW'(0);
        end
        i_complete = 1'b1;
        @(posedge clk); #1;
        i_complete = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({o_cycles, o_err, o_qbit_num} !== {32'(cdelay), 1'b0, MQW'(q)}) begin
            tests_failed++;
            $display("FAIL run_cycles: got cycles=%0d err=%0b qbit=%0d, required %0d 0 %0d",
                     o_cycles, o_err, o_qbit_num, cdelay, q);
        end

        for (int a = 0; a < n; a++) begin
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (o_rd_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_valid: got no valid for address %0d, required valid", a);
                return;
            end
            repeat (stall) @(posedge clk);
            #1 i_rd_ready = 1'b1;
            @(posedge clk); #1;
            i_rd_ready = 1'b0;
        end

        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_done) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL done_seen: got o_done=0 within budget, required 1");
            return;
        end
        @(negedge clk);
        tests_run++;
        if ({o_done, o_busy, o_cycles} !== {1'b0, 1'b0, 32'(cdelay)}) begin
            tests_failed++;
            $display("FAIL done_pulse: got done=%0b busy=%0b cycles=%0d, required 0 0 %0d",
                     o_done, o_busy, o_cycles, cdelay);
        end
        tests_run++;
        if (ctx_q.size() + st_q.size() + rd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending ctx/state/rd, required 0/0/0",
                     ctx_q.size(), st_q.size(), rd_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%0b err=%0b cycles=%0h qbit=%0d, required all 0",
                     o_busy, o_err, o_cycles, o_qbit_num);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got busy=%0b err=%0b, required idle with all outputs 0", o_busy, o_err);
        end
        last_q = 0;
    endtask

    task automatic test_basic();
        run_flow(4, 3, 100, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reject();
        int bad[3] = '{2, SAW + 3, 0};
        for (int i = 0; i < 3; i++) begin
            pulse_go(bad[i], 5);
            @(negedge clk);
            tests_run++;
            if ({o_err, o_busy, o_qbit_num} !== {1'b1, 1'b0, MQW'(last_q)}) begin
                tests_failed++;
                $display("FAIL go_reject: q=%0d got err=%0b busy=%0b qbit=%0d, required 1 0 %0d",
                         bad[i], o_err, o_busy, o_qbit_num, last_q);
            end
        end
    endtask

    task automatic test_readout_stall();
        run_flow(3, 2, 5, 5, 1'b0, 1'b0);
    endtask

    task automatic test_ins_zero_go_in_run();
        run_flow(3, 0, 10, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_init();
        bit found;
        seed = seed + 16'd1;
        for (int a = 0; a < (1 << SAW); a++) st_q.push_back('{addr: SAW'(a), data: (a == 0) ? AMP_TOP : '0});
        pulse_go(SAW + 2, 0);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_state_wea != '0 && o_state_addra == SAW'(10)) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL init_seen: got no state write at address 10, required one");
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_init: got busy=%0b ena=%h addr=%0h qbit=%0d, required all 0",
                     o_busy, o_state_ena, o_state_addra, o_qbit_num);
        end
        ctx_q.delete();
        st_q.delete();
        rd_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        last_q = 0;
        run_flow(SAW + 2, 2, 20, 1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion in time, required $finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        i_go        = 1'b0;
        i_qbit_num  = '0;
        i_ins_num   = '0;
        i_ctx_valid = 1'b0;
        i_ctx_word  = '0;
        i_complete  = 1'b0;
        i_rd_ready  = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_reject();
        test_readout_stall();
        test_ins_zero_go_in_run();
        test_reset_mid_init();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qea_host_loader.md
QEA_HOST_LOADER -- requirements
Module: qea_host_loader

Interface
REQ-001 SHALL have parameter PE_NUM, default 4, number of QEA processing elements (state lanes).
REQ-002 SHALL have parameter STATE_DATA_WIDTH, default 64, one complex amplitude per lane (re[63:32], im[31:0]).
REQ-003 SHALL have parameter STATE_ADDR_WIDTH, default 16, state RAM address width.
REQ-004 SHALL have parameter GATE_CONTEXT_ADDR_WIDTH, default 16, context RAM address width.
REQ-005 SHALL have parameter MAX_QBIT_WIDTH, default 6, qubit-count field width.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_go  in  1  one-cycle pulse; starts a run.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled on i_go.
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, sampled on i_go.
- i_ctx_valid  in  1  context stream valid.
- o_ctx_ready  out  1  context stream ready.
- i_ctx_word  in  64  context stream data.
- o_start  out  1  QEA start pulse.
- o_qbit_num  out  MAX_QBIT_WIDTH  registered qubit count to QEA.
- o_ctx_en, o_ctx_wea  out  1 each  context RAM strobes.
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address.
- o_ctx_data  out  64  context RAM write data.
- o_state_ena, o_state_wea  out  PE_NUM each  per-lane state RAM strobes.
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM address.
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write data.
- i_complete  in  1  QEA completion level.
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data.
- o_rd_valid  out  1  readout stream valid.
- i_rd_ready  in  1  readout stream ready.
- o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readout data.
- o_busy  out  1  high outside IDLE.
- o_done  out  1  one-cycle pulse at end of run.
- o_err  out  1  sticky; set on rejected i_go, cleared by next accepted i_go.
- o_cycles  out  32  cycles from o_start to i_complete, saturating at 0xFFFFFFFF.

Function
REQ-007 SHALL implement FSM IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE.
REQ-008 IDLE: i_go with 3 <= i_qbit_num <= STATE_ADDR_WIDTH+2 SHALL register inputs and go to LOAD_CTX (INIT_STATE if i_ins_num==0); otherwise set o_err and stay in IDLE.
REQ-009 i_go outside IDLE SHALL be ignored, with no o_err change.
REQ-010 LOAD_CTX: o_ctx_ready=1; each valid&ready cycle SHALL assert o_ctx_en=o_ctx_wea=1 next cycle, o_ctx_data=word, o_ctx_addr=0,1,2,...; after i_ins_num words -> INIT_STATE.
REQ-011 Strobes SHALL be low in cycles without a transfer (stream stalls allowed).
REQ-012 INIT_STATE SHALL write N=2^(qbit_num-2) addresses 0..N-1, one per cycle, all ena/wea lanes =1.
REQ-013 Address 0 SHALL get the top lane (MSB 64 bits) = 0x40000000_00000000 and other lanes 0; all other addresses SHALL get all zero (basis state |0>, Q2.30 one).
REQ-014 START SHALL hold o_start=1 for exactly one cycle and clear o_cycles -> RUN.
REQ-015 RUN SHALL increment o_cycles each cycle until i_complete=1, then go to RD_ADDR.
REQ-016 Readout SHALL loop over addresses 0..N-1: RD_ADDR (ena=1, wea=0) -> RD_WAIT (one-cycle RAM latency) -> RD_OUT (capture i_state_dout into o_rd_data, o_rd_valid=1).
REQ-017 o_rd_data SHALL be stable while o_rd_valid=1 and i_rd_ready=0; on handshake -> next address or DONE after N-1.
REQ-018 DONE SHALL pulse o_done one cycle -> IDLE; o_cycles SHALL hold until next START.
REQ-019 Address counters SHALL be STATE_ADDR_WIDTH wide; qbit_num=STATE_ADDR_WIDTH+2 writes the full range with no wrap past N-1.
REQ-020 o_qbit_num SHALL be driven continuously from the registered value.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE and all outputs to 0, including o_err, o_cycles and o_qbit_num, in any state including mid-load or mid-run.
REQ-022 After reset release, the first accepted i_go SHALL restart the run from LOAD_CTX address 0.

Verification
REQ-023 go, qbit=4, ins=3, words A,B,C with one stall cycle -> ctx writes addr 0,1,2 = A,B,C; state writes addr 0..3 with addr0 top lane 0x40000000_00000000.
REQ-024 go, qbit=2 -> o_err=1, o_busy=0, no strobes; next valid go -> o_err=0.
REQ-025 i_complete raised 100 cycles after o_start -> o_cycles=100; o_start high exactly one cycle.
REQ-026 Readout with i_rd_ready low 5 cycles per word, qbit=3 -> 2 words, data stable while stalled, then o_done pulse.
REQ-027 rst_n low during INIT_STATE -> all outputs 0 immediately; fresh go completes normally.
REQ-028 ins=0 -> no ctx strobes, flow goes directly to INIT_STATE; i_go during RUN ignored.
